// File: rtl/wbs_leaf_word_packer.sv
// ---------------------------------------------------------------------------
// wbs_leaf_word_packer
//   Wishbone slave that pairs two 32-bit firmware writes (lower half at +0,
//   upper half at +4) into one 64-bit write to a leaf/query SRAM loader over
//   a valid/ready handshake. Every bus cycle that hits the region is acked
//   exactly once. Protocol errors are counted, and a status word can be read.
//
// Ports
//   wb_clk_i    : clock
//   rst_n       : asynchronous active-low reset
//   wbs_cyc_i   : Wishbone cycle
//   wbs_stb_i   : Wishbone strobe
//   wbs_we_i    : 1 = write, 0 = read
//   wbs_sel_i   : byte selects (writes need 4'hF)
//   wbs_adr_i   : byte address
//   wbs_dat_i   : write data
//   wbs_ack_o   : one-cycle acknowledge
//   wbs_dat_o   : read data, zero whenever ack is low
//   mem_wvalid  : downstream write request
//   mem_wready  : downstream accepts the request
//   mem_waddr   : downstream 64-bit word index
//   mem_wdata   : {upper half, lower half}
//   word_cnt    : completed 64-bit writes (wraps)
//   err_cnt     : protocol errors (saturates)
// ---------------------------------------------------------------------------
module wbs_leaf_word_packer #(
  parameter logic [31:0] BASE_ADDR   = 32'h3002_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
  parameter int          WORD_ADDR_W = 9
) (
  input  logic                   wb_clk_i,
  input  logic                   rst_n,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   mem_wvalid,
  input  logic                   mem_wready,
  output logic [WORD_ADDR_W-1:0] mem_waddr,
  output logic [63:0]            mem_wdata,
  output logic [15:0]            word_cnt,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_lo_hold;
  logic [WORD_ADDR_W-1:0] r_lo_idx;
  logic                   r_lo_valid;
  logic [31:0]            r_rdata;
  logic [WORD_ADDR_W-1:0] r_waddr;
  logic [63:0]            r_wdata;
  logic [15:0]            r_word_cnt;
  logic [7:0]             r_err_cnt;

  logic                   w_hit;
  logic                   w_upper;
  logic [WORD_ADDR_W-1:0] w_idx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_hit   = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_upper = wbs_adr_i[2];
  assign w_idx   = wbs_adr_i[WORD_ADDR_W+2:3];

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lo_hold  <= '0;
      r_lo_idx   <= '0;
      r_lo_valid <= 1'b0;
      r_rdata    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdata <= '0;
          if (w_hit) begin
            if (wbs_we_i) begin
              if (wbs_sel_i != 4'hF) begin
                // Partial writes are rejected outright; pairing state is untouched.
                r_err_cnt <= sat_inc8(r_err_cnt);
                r_state   <= S_ACK;
              end else if (!w_upper) begin
                // A repeated lower half simply replaces the held one.
                r_lo_hold  <= wbs_dat_i;
                r_lo_idx   <= w_idx;
                r_lo_valid <= 1'b1;
                r_state    <= S_ACK;
              end else if (r_lo_valid && (w_idx == r_lo_idx)) begin
                r_waddr <= w_idx;
                r_wdata <= {wbs_dat_i, r_lo_hold};
                r_state <= S_MEM;
              end else begin
                // Orphan or mismatched upper half: drop the pairing entirely.
                r_err_cnt  <= sat_inc8(r_err_cnt);
                r_lo_valid <= 1'b0;
                r_state    <= S_ACK;
              end
            end else begin
              r_rdata <= w_upper ? {r_err_cnt, 7'b0, r_lo_valid, r_word_cnt} : r_lo_hold;
              r_state <= S_ACK;
            end
          end
        end
        S_MEM: begin
          // The downstream write always completes, even if the master has left.
          if (mem_wready) begin
            r_word_cnt <= r_word_cnt + 16'd1;
            r_lo_valid <= 1'b0;
            r_state    <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ack is gated by the live strobe so an aborted master never sees a stray ack.
  assign wbs_ack_o  = (r_state == S_ACK) & wbs_cyc_i & wbs_stb_i;
  assign wbs_dat_o  = wbs_ack_o ? r_rdata : 32'h0;
  assign mem_wvalid = (r_state == S_MEM);
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  assign word_cnt   = r_word_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_wbs_leaf_word_packer.sv
module tb_wbs_leaf_word_packer;

  localparam logic [31:0] BASE = 32'h3002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        ack;
  logic [31:0] dat_o;
  logic        mem_wvalid;
  logic        mem_wready = 1'b1;
  logic [8:0]  mem_waddr;
  logic [63:0] mem_wdata;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  wbs_leaf_word_packer #(
    .BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_0000), .WORD_ADDR_W(9)
  ) dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: pairing state, counters, queue of expected mem writes.
  logic [31:0] m_lo_hold;
  logic [8:0]  m_lo_idx;
  logic        m_lo_valid;
  logic [15:0] m_word;
  logic [7:0]  m_err;
  logic [72:0] exp_q[$];

  int          n_writes = 0, n_acks = 0, exp_acks = 0;
  int          run_len = 0, last_run = 0;
  logic        prev_ack = 1'b0;
  logic [8:0]  last_waddr = '0;
  logic [63:0] last_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_clear();
    m_lo_hold = '0; m_lo_idx = '0; m_lo_valid = 1'b0; m_word = '0; m_err = '0;
    exp_q.delete();
    n_writes = 0;
  endtask

  // Applies one bus transfer to the model; returns the read data it must produce.
  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd);
    logic [8:0] idx;
    idx = a[11:3];
    rd  = '0;
    if (w) begin
      if (s != 4'hF) m_err = sat8(m_err);
      else if (!a[2]) begin
        m_lo_hold = d; m_lo_idx = idx; m_lo_valid = 1'b1;
      end else if (m_lo_valid && idx == m_lo_idx) begin
        exp_q.push_back({idx, d, m_lo_hold});
        m_word = m_word + 16'd1;
        m_lo_valid = 1'b0;
      end else begin
        m_err = sat8(m_err);
        m_lo_valid = 1'b0;
      end
    end else begin
      rd = a[2] ? {m_err, 7'b0, m_lo_valid, m_word} : m_lo_hold;
    end
  endtask

  // Compare process: mem writes against the model queue, ack/data rules.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ack = 1'b0;
        run_len  = 0;
      end else begin
        if (ack) begin
          chk("ack_not_back_to_back", {63'b0, prev_ack}, 64'd0);
          n_acks++;
        end else begin
          chk("dat_o_zero_without_ack", {32'b0, dat_o}, 64'd0);
        end
        prev_ack = ack;
        if (mem_wvalid) begin
          run_len++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_mem_write: addr %0h data %0h, expected none", mem_waddr, mem_wdata);
          end else begin
            chk("mem_waddr", {55'b0, mem_waddr}, {55'b0, exp_q[0][72:64]});
            chk("mem_wdata", mem_wdata, exp_q[0][63:0]);
            if (mem_wready) begin
              void'(exp_q.pop_front());
              n_writes++;
              last_waddr = mem_waddr;
              last_wdata = mem_wdata;
            end
          end
        end else if (run_len != 0) begin
          last_run = run_len;
          run_len  = 0;
        end
      end
    end
  end

  // One Wishbone transfer; starts just after a rising edge and ends likewise.
  task automatic xfer(input logic w, input logic [31:0] off, input logic [31:0] d,
                      input logic [3:0] s, input bit hold,
                      output logic [31:0] rd, output int lat);
    logic [31:0] a, exp_rd;
    bit got;
    a = BASE + off;
    model_apply(w, a, d, s, exp_rd);
    exp_acks++;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = 0; rd = '0; got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (ack) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout: addr %0h no ack after %0d cycles, expected ack", a, lat);
    end else begin
      rd = dat_o;
      if (!w) chk("read_data", {32'b0, rd}, {32'b0, exp_rd});
    end
    @(posedge clk); #1;
    if (!hold) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {63'b0, ack}, 64'd0);
    chk("rst_wvalid", {63'b0, mem_wvalid}, 64'd0);
    chk("rst_waddr", {55'b0, mem_waddr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_counters", {40'b0, err_cnt, word_cnt}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_word_cnt"}, {48'b0, word_cnt}, {48'b0, m_word});
    chk({name, "_err_cnt"}, {56'b0, err_cnt}, {56'b0, m_err});
  endtask

  logic [31:0] rd;
  int lat, k;

  initial begin
    do_reset();

    // 1: basic pair, ready high
    mem_wready = 1'b1;
    xfer(1, 32'h0, 32'h1234_5678, 4'hF, 0, rd, lat);
    chk("t1_lower_latency", lat, 2);
    xfer(1, 32'h4, 32'h9ABC_DEF0, 4'hF, 0, rd, lat);
    chk("t1_upper_latency", lat, 3);
    chk("t1_writes", n_writes, 1);
    chk("t1_waddr", {55'b0, last_waddr}, 64'd0);
    chk("t1_wdata", last_wdata, 64'h9ABC_DEF0_1234_5678);
    chk("t1_word_cnt", {48'b0, word_cnt}, 64'd1);

    // 2: top word with downstream back-pressure for 5 cycles
    mem_wready = 1'b0;
    xfer(1, 32'h1FF8, 32'hAAAA_0001, 4'hF, 0, rd, lat);
    fork
      xfer(1, 32'h1FFC, 32'hBBBB_0002, 4'hF, 0, rd, lat);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_wvalid && k < 20);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        mem_wready = 1'b1;
      end
    join
    chk("t2_wvalid_cycles", last_run, 6);
    chk("t2_upper_latency", lat, 8);
    chk("t2_waddr", {55'b0, last_waddr}, 64'd511);
    chk("t2_wdata", last_wdata, 64'hBBBB_0002_AAAA_0001);
    chk("t2_word_cnt", {48'b0, word_cnt}, 64'd2);

    // 3: orphan and mismatched upper halves
    xfer(1, 32'hC, 32'h1111_1111, 4'hF, 0, rd, lat);
    chk("t3_orphan_err", {56'b0, err_cnt}, 64'd1);
    xfer(1, 32'h0, 32'h2222_2222, 4'hF, 0, rd, lat);
    xfer(1, 32'hC, 32'h3333_3333, 4'hF, 0, rd, lat);
    chk("t3_mismatch_err", {56'b0, err_cnt}, 64'd2);
    chk("t3_writes", n_writes, 2);

    // 4: partial select, then status reads
    xfer(1, 32'h10, 32'hCAFE_F00D, 4'hF, 0, rd, lat);
    xfer(1, 32'h14, 32'hDEAD_BEEF, 4'h3, 0, rd, lat);
    chk("t4_sel_err_latency", lat, 2);
    xfer(0, 32'h4, 32'h0, 4'hF, 0, rd, lat);
    chk("t4_status", {32'b0, rd}, 64'h0301_0002);
    xfer(0, 32'h0, 32'h0, 4'hF, 0, rd, lat);
    chk("t4_lo_hold", {32'b0, rd}, 64'hCAFE_F00D);
    chk_counters("t4");

    // non-hit traffic belongs to another slave
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'h3001_0000; dat = 32'h5555_5555;
    repeat (4) begin
      @(negedge clk);
      chk("nonhit_no_ack", {63'b0, ack}, 64'd0);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfer(0, 32'h0, 32'h0, 4'hF, 0, rd, lat);
    chk_counters("nonhit");

    // 5: all 512 words with strobe held between transfers
    do_reset();
    for (int i = 0; i < 512; i++) begin
      xfer(1, i * 8, 32'h1000_0000 + i, 4'hF, 1, rd, lat);
      xfer(1, i * 8 + 4, 32'h2000_0000 ^ (i << 4), 4'hF, (i != 511), rd, lat);
    end
    chk("t5_writes", n_writes, 512);
    chk("t5_word_cnt", {48'b0, word_cnt}, 64'd512);
    chk("t5_err_cnt", {56'b0, err_cnt}, 64'd0);
    chk("t5_queue_drained", exp_q.size(), 0);

    // 6: reset while a write is pending downstream
    xfer(1, 32'h20, 32'h7777_0000, 4'hF, 0, rd, lat);
    mem_wready = 1'b0;
    model_apply(1, BASE + 32'h24, 32'h8888_0000, 4'hF, rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h24; dat = 32'h8888_0000; sel = 4'hF;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_wvalid && k < 10);
    chk("t6_in_mem", {63'b0, mem_wvalid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wvalid", {63'b0, mem_wvalid}, 64'd0);
    chk("t6_rst_ack", {63'b0, ack}, 64'd0);
    chk("t6_rst_word_cnt", {48'b0, word_cnt}, 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_wready = 1'b1;
    xfer(1, 32'h24, 32'h8888_0000, 4'hF, 0, rd, lat);
    chk("t6_upper_after_reset_err", {56'b0, err_cnt}, 64'd1);
    chk("t6_no_write", n_writes, 0);

    // error counter saturation
    for (int i = 0; i < 260; i++) xfer(1, 32'h8, 32'h0, 4'h0, 0, rd, lat);
    chk("err_saturates", {56'b0, err_cnt}, 64'hFF);
    chk_counters("final");

    chk("ack_count", n_acks, exp_acks);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
